// File: rtl/mem_stage_pkg.sv
// mem_stage shared types: FSM encoding and default timeout.
// Included by every mem_stage slice file.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ack handshake between mem_stage and dmem.
// master = pipeline stage, slave = memory.
interface mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load / bubble control.
// Bubble clears the write enable and holds the data fields.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_rd,
  input  logic        i_we,
  output logic [31:0] o_data,
  output logic [4:0]  o_rd,
  output logic        o_we
);

  logic [31:0] r_data;
  logic [4:0]  r_rd;
  logic        r_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rd   <= '0;
      r_we   <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_rd   <= i_rd;
      r_we   <= i_we;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_rd   = r_rd;
  assign o_we   = r_we;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: word load/store over a req/ack data bus.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        branch,
  input  logic        jump,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] alu_in,
  input  logic [31:0] readdata2,
  input  logic [4:0]  RegRd,
  mem_stage_if.master mem,
  output logic        stall,
  output logic        PCSrc,
  output logic        jump_out,
  output logic [31:0] regExMem,
  output logic [4:0]  MEMRegRd_wire,
  output logic        MEM_RegWrite_wire,
  output logic [31:0] regMemWb,
  output logic [4:0]  WBRegRd_wire,
  output logic        WB_RegWrite_wire,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_t      r_state;
  logic        w_mem_op;
  logic        w_in_err;
  logic        w_stall;
  logic        w_load;
  logic [31:0] w_wb_data;

  assign w_mem_op = MemRead | MemWrite;
  assign w_in_err = (r_state == S_ERR);
  assign w_stall  = ~w_in_err & w_mem_op
                  & ~mem.dmem_ack;
  assign w_load   = ~w_stall & ~w_in_err;

  assign mem.dmem_req   = RST & ~w_in_err
                        & (w_mem_op | (r_state == S_WAIT));
  assign mem.dmem_we    = MemWrite;
  assign mem.dmem_addr  = {alu_in[31:2], 2'b00};
  assign mem.dmem_wdata = readdata2;

  assign w_wb_data = MemtoReg ? mem.dmem_rdata : alu_in;

  assign stall    = w_stall;
  assign PCSrc    = branch & alu_in[0] & ~w_stall;
  assign jump_out = jump & ~w_stall;

  assign regExMem          = alu_in;
  assign MEMRegRd_wire     = RegRd;
  assign MEM_RegWrite_wire = RegWrite;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_bus_err;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_mem_op & ~mem.dmem_ack)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem.dmem_ack) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_ERR;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus_err = r_bus_err;
`else
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_mem_op & ~mem.dmem_ack)
            r_state <= S_WAIT;
        S_WAIT:
          if (mem.dmem_ack)
            r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_err = 1'b0;
`endif

  mem_wb_reg u_mem_wb (
    .clk    (CLK),
    .rst_n  (RST),
    .i_load (w_load),
    .i_data (w_wb_data),
    .i_rd   (RegRd),
    .i_we   (RegWrite),
    .o_data (regMemWb),
    .o_rd   (WBRegRd_wire),
    .o_we   (WB_RegWrite_wire)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, passthrough,
// branches, reset during WAIT and (optionally) timeout.
module tb_mem_stage;

  logic        CLK;
  logic        RST;
  logic        branch, jump, MemRead, MemWrite;
  logic        MemtoReg, RegWrite;
  logic [31:0] alu_in, readdata2;
  logic [4:0]  RegRd;
  logic        stall, PCSrc, jump_out;
  logic [31:0] regExMem, regMemWb;
  logic [4:0]  MEMRegRd_wire, WBRegRd_wire;
  logic        MEM_RegWrite_wire, WB_RegWrite_wire;
  logic        bus_err;

  int vecs = 0;
  int errs = 0;

  mem_stage_if dmem ();

  mem_stage dut (
    .CLK               (CLK),
    .RST               (RST),
    .branch            (branch),
    .jump              (jump),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemtoReg          (MemtoReg),
    .RegWrite          (RegWrite),
    .alu_in            (alu_in),
    .readdata2         (readdata2),
    .RegRd             (RegRd),
    .mem               (dmem.master),
    .stall             (stall),
    .PCSrc             (PCSrc),
    .jump_out          (jump_out),
    .regExMem          (regExMem),
    .MEMRegRd_wire     (MEMRegRd_wire),
    .MEM_RegWrite_wire (MEM_RegWrite_wire),
    .regMemWb          (regMemWb),
    .WBRegRd_wire      (WBRegRd_wire),
    .WB_RegWrite_wire  (WB_RegWrite_wire),
    .bus_err           (bus_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic idle_inputs();
    branch    = 1'b0;
    jump      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    alu_in    = '0;
    readdata2 = '0;
    RegRd     = '0;
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    MemRead = 1'b1;
    alu_in  = 32'h44;
    @(posedge CLK); #1;
    vecs++;
    if (dmem.dmem_req !== 1'b0) begin
      errs++;
      $display("FAIL rst_req got %b exp 0", dmem.dmem_req);
    end
    vecs++;
    if (regMemWb !== 32'h0 || WBRegRd_wire !== 5'd0
        || WB_RegWrite_wire !== 1'b0) begin
      errs++;
      $display("FAIL rst_wb got %h/%0d/%b exp 0/0/0",
               regMemWb, WBRegRd_wire, WB_RegWrite_wire);
    end
    vecs++;
    if (bus_err !== 1'b0) begin
      errs++;
      $display("FAIL rst_buserr got %b exp 0", bus_err);
    end
    vecs++;
    if (regExMem !== 32'h44) begin
      errs++;
      $display("FAIL rst_fwd got %h exp 44", regExMem);
    end
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
  endtask

  task automatic test_load_zero_wait();
    @(negedge CLK);
    MemRead  = 1'b1;
    MemtoReg = 1'b1;
    RegWrite = 1'b1;
    RegRd    = 5'd5;
    alu_in   = 32'h40;
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hDEADBEEF;
    #1;
    vecs++;
    if (dmem.dmem_addr !== 32'h40 || dmem.dmem_req !== 1'b1
        || dmem.dmem_we !== 1'b0) begin
      errs++;
      $display("FAIL ld0_bus got %h/%b/%b exp 40/1/0",
               dmem.dmem_addr, dmem.dmem_req, dmem.dmem_we);
    end
    vecs++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL ld0_stall got %b exp 0", stall);
    end
    @(posedge CLK); #1;
    vecs++;
    if (regMemWb !== 32'hDEADBEEF || WBRegRd_wire !== 5'd5
        || WB_RegWrite_wire !== 1'b1) begin
      errs++;
      $display("FAIL ld0_wb got %h/%0d/%b exp deadbeef/5/1",
               regMemWb, WBRegRd_wire, WB_RegWrite_wire);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_load_wait3();
    @(negedge CLK);
    MemRead  = 1'b1;
    MemtoReg = 1'b1;
    RegWrite = 1'b1;
    RegRd    = 5'd9;
    alu_in   = 32'h80;
    dmem.dmem_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (stall !== 1'b1 || dmem.dmem_req !== 1'b1) begin
        errs++;
        $display("FAIL ldw_stall%0d got %b/%b exp 1/1",
                 i, stall, dmem.dmem_req);
      end
      @(posedge CLK); #1;
      vecs++;
      if (WB_RegWrite_wire !== 1'b0) begin
        errs++;
        $display("FAIL ldw_bubble%0d got %b exp 0",
                 i, WB_RegWrite_wire);
      end
      @(negedge CLK);
    end
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hCAFEF00D;
    #1;
    vecs++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL ldw_ackstall got %b exp 0", stall);
    end
    @(posedge CLK); #1;
    vecs++;
    if (regMemWb !== 32'hCAFEF00D || WBRegRd_wire !== 5'd9
        || WB_RegWrite_wire !== 1'b1) begin
      errs++;
      $display("FAIL ldw_wb got %h/%0d/%b exp cafef00d/9/1",
               regMemWb, WBRegRd_wire, WB_RegWrite_wire);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_store();
    @(negedge CLK);
    MemWrite  = 1'b1;
    alu_in    = 32'h103;
    readdata2 = 32'h12345678;
    RegRd     = 5'd3;
    #1;
    vecs++;
    if (dmem.dmem_we !== 1'b1 || dmem.dmem_addr !== 32'h100
        || dmem.dmem_wdata !== 32'h12345678) begin
      errs++;
      $display("FAIL st_bus got %b/%h/%h exp 1/100/12345678",
               dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata);
    end
    vecs++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL st_stall got %b exp 1", stall);
    end
    @(posedge CLK);
    @(negedge CLK);
    dmem.dmem_ack = 1'b1;
    #1;
    vecs++;
    if (stall !== 1'b0 || dmem.dmem_req !== 1'b1) begin
      errs++;
      $display("FAIL st_ack got %b/%b exp 0/1",
               stall, dmem.dmem_req);
    end
    @(posedge CLK); #1;
    vecs++;
    if (WB_RegWrite_wire !== 1'b0) begin
      errs++;
      $display("FAIL st_wbwe got %b exp 0", WB_RegWrite_wire);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    vecs++;
    if (dmem.dmem_req !== 1'b0) begin
      errs++;
      $display("FAIL st_idle got %b exp 0", dmem.dmem_req);
    end
  endtask

  task automatic test_rtype();
    @(negedge CLK);
    alu_in   = 32'd3;
    RegWrite = 1'b1;
    RegRd    = 5'd8;
    #1;
    vecs++;
    if (regExMem !== 32'd3 || MEMRegRd_wire !== 5'd8
        || MEM_RegWrite_wire !== 1'b1) begin
      errs++;
      $display("FAIL rt_fwd got %h/%0d/%b exp 3/8/1",
               regExMem, MEMRegRd_wire, MEM_RegWrite_wire);
    end
    vecs++;
    if (dmem.dmem_req !== 1'b0 || stall !== 1'b0) begin
      errs++;
      $display("FAIL rt_req got %b/%b exp 0/0",
               dmem.dmem_req, stall);
    end
    @(posedge CLK); #1;
    vecs++;
    if (regMemWb !== 32'd3 || WBRegRd_wire !== 5'd8
        || WB_RegWrite_wire !== 1'b1) begin
      errs++;
      $display("FAIL rt_wb got %h/%0d/%b exp 3/8/1",
               regMemWb, WBRegRd_wire, WB_RegWrite_wire);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_branch();
    @(negedge CLK);
    branch = 1'b1;
    alu_in = 32'd1;
    #1;
    vecs++;
    if (PCSrc !== 1'b1) begin
      errs++;
      $display("FAIL br_taken got %b exp 1", PCSrc);
    end
    alu_in = 32'd0;
    #1;
    vecs++;
    if (PCSrc !== 1'b0) begin
      errs++;
      $display("FAIL br_not got %b exp 0", PCSrc);
    end
    branch = 1'b0;
    jump   = 1'b1;
    #1;
    vecs++;
    if (jump_out !== 1'b1) begin
      errs++;
      $display("FAIL jmp got %b exp 1", jump_out);
    end
    MemRead = 1'b1;
    #1;
    vecs++;
    if (jump_out !== 1'b0) begin
      errs++;
      $display("FAIL jmp_stall got %b exp 0", jump_out);
    end
    dmem.dmem_ack = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    @(negedge CLK);
    MemRead  = 1'b1;
    RegWrite = 1'b1;
    RegRd    = 5'd7;
    alu_in   = 32'h200;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    vecs++;
    if (dmem.dmem_req !== 1'b0) begin
      errs++;
      $display("FAIL rw_req got %b exp 0", dmem.dmem_req);
    end
    @(posedge CLK); #1;
    vecs++;
    if (regMemWb !== 32'h0 || WBRegRd_wire !== 5'd0
        || WB_RegWrite_wire !== 1'b0 || bus_err !== 1'b0) begin
      errs++;
      $display("FAIL rw_regs got %h/%0d/%b/%b exp 0/0/0/0",
               regMemWb, WBRegRd_wire, WB_RegWrite_wire, bus_err);
    end
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    vecs++;
    if (dmem.dmem_req !== 1'b0) begin
      errs++;
      $display("FAIL rw_idle got %b exp 0", dmem.dmem_req);
    end
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    MemRead  = 1'b1;
    RegWrite = 1'b1;
    RegRd    = 5'd4;
    alu_in   = 32'h300;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 17; i++) @(posedge CLK);
    #1;
    vecs++;
    if (bus_err !== 1'b1 || stall !== 1'b0
        || dmem.dmem_req !== 1'b0) begin
      errs++;
      $display("FAIL to_err got %b/%b/%b exp 1/0/0",
               bus_err, stall, dmem.dmem_req);
    end
    @(posedge CLK); #1;
    vecs++;
    if (WB_RegWrite_wire !== 1'b0) begin
      errs++;
      $display("FAIL to_bubble got %b exp 0", WB_RegWrite_wire);
    end
    @(negedge CLK);
    idle_inputs();
    @(posedge CLK); #1;
    vecs++;
    if (bus_err !== 1'b1) begin
      errs++;
      $display("FAIL to_sticky got %b exp 1", bus_err);
    end
`else
    for (int i = 0; i < 20; i++) @(posedge CLK);
    #1;
    vecs++;
    if (bus_err !== 1'b0 || stall !== 1'b1
        || dmem.dmem_req !== 1'b1) begin
      errs++;
      $display("FAIL nto_wait got %b/%b/%b exp 0/1/1",
               bus_err, stall, dmem.dmem_req);
    end
    @(negedge CLK);
    dmem.dmem_ack = 1'b1;
    @(posedge CLK); #1;
    vecs++;
    if (WB_RegWrite_wire !== 1'b1 || regMemWb !== 32'h300) begin
      errs++;
      $display("FAIL nto_done got %b/%h exp 1/300",
               WB_RegWrite_wire, regMemWb);
    end
    @(negedge CLK);
    idle_inputs();
`endif
  endtask

  initial begin
    RST = 1'b0;
    idle_inputs();
    test_reset();
    test_load_zero_wait();
    test_load_wait3();
    test_store();
    test_rtype();
    test_branch();
    test_reset_in_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of `EXECUTE`. It consumes the registered EX/MEM outputs and performs word loads and stores over a variable-latency data-memory handshake. It stalls the upstream pipeline while an access is outstanding and drives the MEM/WB register plus the forwarding and branch-resolution signals back to `EXECUTE` and fetch.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum wait cycles for `dmem_ack`. Used only when `MEM_TIMEOUT_EN` is defined. Must be ≥2.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-low reset. Sampled on the `CLK` rising edge.
- `branch`, `jump`, `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`  in  1 each  EX/MEM control signals.
- `alu_in`  in  32  EX/MEM ALU result. It is the memory address for loads and stores, and bit 0 is the compare result for branches.
- `readdata2`  in  32  store data.
- `RegRd`  in  5  destination register, already muxed by `RegDst`.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  word address; bits [1:0] are forced to 0.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  load data; valid only in a cycle where `dmem_ack` = 1.
- `dmem_ack`  in  1  access complete.
- `stall`  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `PCSrc`  out  1  branch taken.
- `jump_out`  out  1  jump passthrough.
- `regExMem`, `MEMRegRd_wire`, `MEM_RegWrite_wire`  out  32/5/1  combinational forwarding sources, equal to `alu_in`, `RegRd` and `RegWrite`.
- `regMemWb`, `WBRegRd_wire`, `WB_RegWrite_wire`  out  32/5/1  registered MEM/WB write-back value, destination register and write enable.
- `bus_err`  out  1  sticky flag for a timed-out memory access.

## Operation
- A memory op is `mem_op = MemRead | MemWrite`. `MemRead` and `MemWrite` are never both set.
- FSM states are IDLE, WAIT and (with the macro) ERR.
- **IDLE**
  - `dmem_req` = `mem_op`, combinationally, in the same cycle the EX/MEM values are presented.
  - If `mem_op` and `dmem_ack` are both set: the access completes with zero wait and the state stays IDLE.
  - If `mem_op` is set and `dmem_ack` is not: go to WAIT.
- **WAIT**
  - `dmem_req` stays at 1. `dmem_addr`, `dmem_we` and `dmem_wdata` stay stable; they are stable because `EX/MEM` is held by `stall`.
  - On `dmem_ack`: the access completes and the state returns to IDLE.
- `stall = mem_op & ~dmem_ack`, in both IDLE and WAIT. `stall` is 0 in the completion cycle.
- The write-back value is `regMemWb = MemtoReg ? dmem_rdata : alu_in`. `dmem_rdata` is captured only in the ack cycle.
- The MEM/WB register loads `{regMemWb, RegRd, RegWrite}` on every edge where `stall` = 0.
- While `stall` = 1, the MEM/WB register loads a bubble: `WB_RegWrite_wire` = 0, and the other MEM/WB fields hold their values.
- `PCSrc = branch & alu_in[0] & ~stall`. `jump_out = jump & ~stall`.
- Forwarding outputs are pure combinational passthrough. They remain valid during a stall.
- Stores write `readdata2` unchanged; there is no byte or halfword support.

## Timing
- Reset, with `RST` = 0 at an edge:
  - state goes to IDLE;
  - `regMemWb`, `WBRegRd_wire` and `WB_RegWrite_wire` go to 0;
  - `bus_err` goes to 0.
- Combinational outputs follow the inputs during reset, except that `dmem_req` is forced to 0 while `RST` = 0.
- Reset asserted in WAIT: `dmem_req` drops in the same cycle, and the outstanding access is abandoned.
- Latency:
  - load/store with zero-wait ack: 1 cycle, with no stall;
  - ack after N wait cycles: N stall cycles, and the result reaches MEM/WB on the edge of the ack cycle.
- The memory must accept a held request; `dmem_req` never drops without an ack except on reset or timeout.
- A non-memory instruction passes through in 1 cycle and never stalls.
- The state does not reach WAIT on a non-memory instruction.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - a counter runs in WAIT;
  - if `TIMEOUT_CYCLES` WAIT cycles pass without an ack, the state goes to ERR;
  - in ERR, `dmem_req` = 0 and `stall` = 0, MEM/WB loads a bubble, `bus_err` is set (sticky until reset), and the state returns to IDLE on the next edge;
  - the counter clears on entering IDLE.
- `MEM_TIMEOUT_EN` undefined: there is no counter and no ERR state, WAIT lasts indefinitely, and `bus_err` is tied to 0.

## Structure
- `mem_stage_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2);
  - the default `TIMEOUT_CYCLES` constant;
  - the shared `Opcode.vh`/`ALUop.vh` includes, as needed.
- Sub-module `mem_wb_reg` is the MEM/WB pipeline register, with load/bubble control.
- The FSM and write-back mux stay in `mem_stage`.

## Test plan
- **Load, zero-wait:** `MemRead`=1, `MemtoReg`=1, `RegWrite`=1, `RegRd`=5, `alu_in`=0x40, `dmem_ack`=1 in the same cycle, `dmem_rdata`=0xDEADBEEF.
  - Required: `dmem_addr`=0x40, `stall` never 1, after 1 edge `regMemWb`=0xDEADBEEF, `WBRegRd_wire`=5, `WB_RegWrite_wire`=1.
- **Load, 3-cycle ack:**
  - Required: `stall`=1 for 3 cycles with `dmem_req` held, `WB_RegWrite_wire`=0 during the stall, and the data captured on the ack edge.
- **Store:** `MemWrite`=1, `alu_in`=0x103, `readdata2`=0x12345678, ack after 1 cycle.
  - Required: `dmem_we`=1, `dmem_addr`=0x100, `dmem_wdata`=0x12345678, `WB_RegWrite_wire`=0.
- **R-type passthrough:** `alu_in`=3, `RegWrite`=1, `RegRd`=8.
  - Required: `regExMem`=3 and `MEMRegRd_wire`=8 immediately; `regMemWb`=3 after 1 edge; no `dmem_req`.
- **BEQ taken / BNE taken:** `branch`=1 with `alu_in`=1.
  - Required: `PCSrc`=1. With `alu_in`=0: `PCSrc`=0.
- **Reset in WAIT / timeout:**
  - `RST`=0 during WAIT: required `dmem_req`=0, state IDLE, all registered outputs 0.
  - With `MEM_TIMEOUT_EN` and no ack for 16 cycles: required `bus_err`=1, `stall` released, MEM/WB bubble.
